axi_lite_to_obi_bridge: RTL and testbench
=========================================

Name: axi_lite_to_obi_bridge

Overview:
- Consumes the offset-translated AXI4-Lite master transactions produced by the SPI-slave address translation stage and converts them into OBI master transactions on the x-heep system bus.
- Single outstanding transaction; reads and writes are arbitrated round-robin.
- Misaligned accesses are rejected locally with SLVERR and never issued on OBI.

Parameters:
- AXI_ADDR_WIDTH, 32, address width on the AXI and OBI sides.
- AXI_DATA_WIDTH, 32, data width; fixed at 32 (strobe width = AXI_DATA_WIDTH/8).

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  async active-low reset
- s_awaddr  in  AXI_ADDR_WIDTH  write address
- s_awvalid / s_awready  in / out  1  AW handshake
- s_wdata  in  AXI_DATA_WIDTH  write data
- s_wstrb  in  4  byte strobes
- s_wvalid / s_wready  in / out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  B handshake
- s_araddr  in  AXI_ADDR_WIDTH  read address
- s_arvalid / s_arready  in / out  1  AR handshake
- s_rdata  out  AXI_DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  R handshake
- obi_req  out  1  OBI request
- obi_gnt  in  1  OBI grant
- obi_addr  out  AXI_ADDR_WIDTH  OBI address
- obi_we  out  1  OBI write enable
- obi_be  out  4  OBI byte enables
- obi_wdata  out  AXI_DATA_WIDTH  OBI write data
- obi_rvalid  in  1  OBI response valid
- obi_rdata  in  AXI_DATA_WIDTH  OBI read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock/reset: reset s00_axi_aresetn, asynchronous, active-low; clock s00_axi_aclk.
- Reset values: all registered outputs 0, state IDLE, prio_read=0.
  - Reset asserted mid-transaction drops obi_req immediately and discards the transaction.
- States: IDLE, W_COLLECT, REQ, WAIT_R, B_RESP, R_RESP.
- Ready signals are combinational from state and capture flags:
  - arready = IDLE & read_sel.
  - awready = (IDLE & write_sel) | (W_COLLECT & !aw_got).
  - wready = (IDLE & write_sel) | (W_COLLECT & !w_got).
- Arbitration in IDLE:
  - write_pending = awvalid | wvalid.
  - read_sel = arvalid & (!write_pending | prio_read).
  - write_sel = write_pending & !read_sel.
  - prio_read toggles only when a write completes (B handshake) → 1, or a read completes (R handshake) → 0.
  - With both types continuously pending, transactions alternate W,R,W,R.
- Write path:
  - IDLE with write_sel: capture whichever of AW/W handshakes that cycle.
    - Both captured → REQ.
    - Otherwise → W_COLLECT, which waits for the missing one, then → REQ.
  - AW and W may arrive in either order, any gap.
- Read path: AR handshake in IDLE captures araddr → REQ.
- Alignment check at entry to REQ:
  - If captured addr[1:0] != 0: skip OBI; go directly to B_RESP/R_RESP with resp=2'b10 (SLVERR); rdata=0.
- REQ:
  - obi_req=1; addr, we, be (=wstrb for writes, 4'hF for reads) and wdata are registered and held stable until obi_gnt.
  - On gnt: deassert req next cycle → WAIT_R.
  - No timeout; REQ holds indefinitely without gnt.
- WAIT_R:
  - obi_rvalid is only honoured in WAIT_R; rvalid never coincides with gnt.
  - On obi_rvalid, latch obi_rdata for reads → R_RESP (read) or B_RESP (write), resp=OKAY.
- B_RESP / R_RESP:
  - bvalid/rvalid held with stable resp/rdata until bready/rready.
  - On handshake → IDLE.
  - New requests are accepted only in IDLE; there is no IDLE bypass.
- Minimum latency, AR handshake to rvalid: 3 cycles, with gnt in the first REQ cycle and rvalid one cycle later.
- wstrb=0 is passed through as be=0; OBI access still issued.

Test Plan:
- Read 0x0000_1000, gnt immediate, rdata 0xDEADBEEF one cycle later → obi_addr=0x1000, we=0, be=F; R: rdata=0xDEADBEEF, rresp=0, rvalid exactly 3 cycles after AR handshake.
- Write with W two cycles before AW, addr 0x2004, wdata 0x12345678, wstrb 4'b0011 → single OBI req: we=1, be=3, wdata=0x12345678; bresp=0.
- gnt withheld 5 cycles → req, addr, wdata stable for 6 cycles; exactly one transfer; no AXI ready asserted meanwhile.
- Misaligned read 0x1002 → no obi_req pulse; rresp=2'b10, rdata=0.
- awvalid, wvalid and arvalid held continuously for 4 transactions → order W,R,W,R; prio_read follows the toggle rule.
- Reset pulsed during WAIT_R → obi_req, bvalid, rvalid, busy all 0; next read completes normally.

Source files
------------

// File: rtl/axi_lite_to_obi_bridge.sv
// AXI4-Lite slave to OBI master bridge.
// Keeps one transaction in flight and arbitrates reads and writes round-robin.
// Misaligned accesses are answered locally with SLVERR and never reach OBI.
module axi_lite_to_obi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  // AXI4-Lite write address / data / response
  input  logic [AXI_ADDR_WIDTH-1:0]     s_awaddr,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  // AXI4-Lite read address / data
  input  logic [AXI_ADDR_WIDTH-1:0]     s_araddr,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  // OBI master
  output logic                          obi_req,
  input  logic                          obi_gnt,
  output logic [AXI_ADDR_WIDTH-1:0]     obi_addr,
  output logic                          obi_we,
  output logic [AXI_DATA_WIDTH/8-1:0]   obi_be,
  output logic [AXI_DATA_WIDTH-1:0]     obi_wdata,
  input  logic                          obi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]     obi_rdata,
  output logic                          busy
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] W_COLLECT = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] WAIT_R    = 3'd3;
  localparam logic [2:0] B_RESP    = 3'd4;
  localparam logic [2:0] R_RESP    = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]                state_q, state_d;
  logic                      prio_read_q, prio_read_d;
  logic                      aw_got_q, aw_got_d;
  logic                      w_got_q, w_got_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;

  logic                      obi_req_d;
  logic [AXI_ADDR_WIDTH-1:0] obi_addr_d;
  logic                      obi_we_d;
  logic [STRB_WIDTH-1:0]     obi_be_d;
  logic [AXI_DATA_WIDTH-1:0] obi_wdata_d;
  logic                      bvalid_d, rvalid_d, busy_d;
  logic [1:0]                bresp_d, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_d;

  logic                      write_pending, read_sel, write_sel;
  logic                      launch, launch_we;
  logic [AXI_ADDR_WIDTH-1:0] launch_addr;
  logic [AXI_DATA_WIDTH-1:0] launch_wdata;
  logic [STRB_WIDTH-1:0]     launch_be;

  // Round-robin arbitration and AXI ready generation
  assign write_pending = s_awvalid | s_wvalid;
  assign read_sel      = s_arvalid & (~write_pending | prio_read_q);
  assign write_sel     = write_pending & ~read_sel;

  assign s_arready = (state_q == IDLE) & read_sel;
  assign s_awready = ((state_q == IDLE) & write_sel) | ((state_q == W_COLLECT) & ~aw_got_q);
  assign s_wready  = ((state_q == IDLE) & write_sel) | ((state_q == W_COLLECT) & ~w_got_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    prio_read_d  = prio_read_q;
    aw_got_d     = aw_got_q;
    w_got_d      = w_got_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    obi_req_d    = obi_req;
    obi_addr_d   = obi_addr;
    obi_we_d     = obi_we;
    obi_be_d     = obi_be;
    obi_wdata_d  = obi_wdata;
    bvalid_d     = s_bvalid;
    bresp_d      = s_bresp;
    rvalid_d     = s_rvalid;
    rresp_d      = s_rresp;
    rdata_d      = s_rdata;
    launch       = 1'b0;
    launch_we    = 1'b0;
    launch_addr  = '0;
    launch_wdata = '0;
    launch_be    = '0;

    case (state_q)
      IDLE: begin
        if (read_sel) begin
          launch      = 1'b1;
          launch_addr = s_araddr;
          launch_be   = {STRB_WIDTH{1'b1}};
        end else if (write_sel) begin
          if (s_awvalid) begin
            aw_got_d = 1'b1;
            addr_d   = s_awaddr;
          end
          if (s_wvalid) begin
            w_got_d = 1'b1;
            wdata_d = s_wdata;
            wstrb_d = s_wstrb;
          end
          if (aw_got_d && w_got_d) begin
            launch       = 1'b1;
            launch_we    = 1'b1;
            launch_addr  = addr_d;
            launch_wdata = wdata_d;
            launch_be    = wstrb_d;
          end else begin
            state_d = W_COLLECT;
          end
        end
      end
      W_COLLECT: begin
        if (s_awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          addr_d   = s_awaddr;
        end
        if (s_wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
        end
        if (aw_got_d && w_got_d) begin
          launch       = 1'b1;
          launch_we    = 1'b1;
          launch_addr  = addr_d;
          launch_wdata = wdata_d;
          launch_be    = wstrb_d;
        end
      end
      REQ: begin
        if (obi_gnt) begin
          obi_req_d = 1'b0;
          state_d   = WAIT_R;
        end
      end
      WAIT_R: begin
        if (obi_rvalid) begin
          if (obi_we) begin
            state_d  = B_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
          end else begin
            state_d  = R_RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = obi_rdata;
          end
        end
      end
      B_RESP: begin
        if (s_bready) begin
          bvalid_d    = 1'b0;
          prio_read_d = 1'b1;
          state_d     = IDLE;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          rvalid_d    = 1'b0;
          prio_read_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Issue on OBI, or answer a misaligned access locally
    if (launch) begin
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
      if (launch_addr[1:0] != 2'b00) begin
        if (launch_we) begin
          state_d  = B_RESP;
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
        end else begin
          state_d  = R_RESP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_SLVERR;
          rdata_d  = '0;
        end
      end else begin
        state_d     = REQ;
        obi_req_d   = 1'b1;
        obi_addr_d  = launch_addr;
        obi_we_d    = launch_we;
        obi_be_d    = launch_be;
        obi_wdata_d = launch_wdata;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q     <= IDLE;
      prio_read_q <= 1'b0;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      obi_req     <= 1'b0;
      obi_addr    <= '0;
      obi_we      <= 1'b0;
      obi_be      <= '0;
      obi_wdata   <= '0;
      s_bvalid    <= 1'b0;
      s_bresp     <= 2'b00;
      s_rvalid    <= 1'b0;
      s_rresp     <= 2'b00;
      s_rdata     <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_read_q <= prio_read_d;
      aw_got_q    <= aw_got_d;
      w_got_q     <= w_got_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      obi_req     <= obi_req_d;
      obi_addr    <= obi_addr_d;
      obi_we      <= obi_we_d;
      obi_be      <= obi_be_d;
      obi_wdata   <= obi_wdata_d;
      s_bvalid    <= bvalid_d;
      s_bresp     <= bresp_d;
      s_rvalid    <= rvalid_d;
      s_rresp     <= rresp_d;
      s_rdata     <= rdata_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_to_obi_bridge.sv
// Directed bench for axi_lite_to_obi_bridge with a small OBI slave responder.
module tb_axi_lite_to_obi_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic        obi_req, obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // OBI slave model state
  int          gnt_delay  = 0;
  int          wcnt       = 0;
  int          req_cycles = 0;
  int          unstable   = 0;
  int          n_xfer     = 0;
  int          rdy_busy   = 0;
  bit          gnt_d      = 1'b0;
  bit          no_rsp     = 1'b0;
  logic [31:0] slv_rdata  = 32'h0;
  logic [31:0] snap_addr  = 32'h0;
  logic [31:0] snap_wdata = 32'h0;
  logic [3:0]  snap_be    = 4'h0;
  logic        snap_we    = 1'b0;

  axi_lite_to_obi_bridge dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s_awaddr        (s_awaddr),
    .s_awvalid       (s_awvalid),
    .s_awready       (s_awready),
    .s_wdata         (s_wdata),
    .s_wstrb         (s_wstrb),
    .s_wvalid        (s_wvalid),
    .s_wready        (s_wready),
    .s_bresp         (s_bresp),
    .s_bvalid        (s_bvalid),
    .s_bready        (s_bready),
    .s_araddr        (s_araddr),
    .s_arvalid       (s_arvalid),
    .s_arready       (s_arready),
    .s_rdata         (s_rdata),
    .s_rresp         (s_rresp),
    .s_rvalid        (s_rvalid),
    .s_rready        (s_rready),
    .obi_req         (obi_req),
    .obi_gnt         (obi_gnt),
    .obi_addr        (obi_addr),
    .obi_we          (obi_we),
    .obi_be          (obi_be),
    .obi_wdata       (obi_wdata),
    .obi_rvalid      (obi_rvalid),
    .obi_rdata       (obi_rdata),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // OBI slave: grant after gnt_delay request cycles, respond one cycle after grant
  initial begin
    obi_gnt    = 1'b0;
    obi_rvalid = 1'b0;
    obi_rdata  = 32'h0;
    forever begin
      tick();
      obi_gnt    = 1'b0;
      obi_rvalid = 1'b0;
      if (obi_req && (s_arready || s_awready || s_wready)) rdy_busy++;
      if (!rst_n) begin
        gnt_d = 1'b0;
        wcnt  = 0;
      end else if (gnt_d) begin
        gnt_d = 1'b0;
        if (!no_rsp) begin
          obi_rvalid = 1'b1;
          obi_rdata  = slv_rdata;
        end
      end else if (obi_req) begin
        req_cycles++;
        if (wcnt == 0) begin
          snap_addr  = obi_addr;
          snap_wdata = obi_wdata;
          snap_be    = obi_be;
          snap_we    = obi_we;
        end else if (obi_addr != snap_addr || obi_wdata != snap_wdata ||
                     obi_be != snap_be || obi_we != snap_we) begin
          unstable++;
        end
        if (wcnt >= gnt_delay) begin
          obi_gnt = 1'b1;
          gnt_d   = 1'b1;
          n_xfer++;
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic ar_hs(input logic [31:0] addr);
    int n = 0;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    #1;
    while (!s_arready && n < 50) begin tick(); n++; end
    if (!s_arready) check("ar_timeout", 64'(s_arready), 64'd1);
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic aw_w(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int lead);
    int n = 0;
    s_wdata  = data;
    s_wstrb  = strb;
    s_wvalid = 1'b1;
    if (lead == 0) begin
      s_awaddr  = addr;
      s_awvalid = 1'b1;
    end
    #1;
    while (!s_wready && n < 50) begin tick(); n++; end
    if (!s_wready) check("w_timeout", 64'(s_wready), 64'd1);
    tick();
    s_wvalid = 1'b0;
    if (lead == 0) s_awvalid = 1'b0;
    if (lead > 0) begin
      repeat (lead - 1) tick();
      s_awaddr  = addr;
      s_awvalid = 1'b1;
      #1;
      n = 0;
      while (!s_awready && n < 50) begin tick(); n++; end
      if (!s_awready) check("aw_timeout", 64'(s_awready), 64'd1);
      tick();
      s_awvalid = 1'b0;
    end
  endtask

  // lat counts cycles from the address handshake cycle to the response cycle
  task automatic wait_rvalid(output int lat);
    lat = 1;
    while (!s_rvalid && lat < 200) begin tick(); lat++; end
    if (!s_rvalid) check("r_timeout", 64'(s_rvalid), 64'd1);
  endtask

  task automatic wait_bvalid(output int lat);
    lat = 1;
    while (!s_bvalid && lat < 200) begin tick(); lat++; end
    if (!s_bvalid) check("b_timeout", 64'(s_bvalid), 64'd1);
  endtask

  task automatic r_done();
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
  endtask

  task automatic b_done();
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
  endtask

  initial begin
    int lat;
    int x0, r0, u0, b0;
    int nseen;
    logic kinds [4];
    logic exp_kind;

    rst_n     = 1'b0;
    s_awaddr  = 32'h0; s_awvalid = 1'b0;
    s_wdata   = 32'h0; s_wstrb   = 4'h0; s_wvalid = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = 32'h0; s_arvalid = 1'b0;
    s_rready  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check("rst_obi_req", 64'(obi_req), 64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_bvalid",  64'(s_bvalid), 64'd0);
    check("rst_rvalid",  64'(s_rvalid), 64'd0);
    check("rst_rdata",   64'(s_rdata),  64'd0);
    check("rst_arready", 64'(s_arready), 64'd0);

    // aligned read, immediate grant
    slv_rdata = 32'hDEADBEEF;
    gnt_delay = 0;
    ar_hs(32'h0000_1000);
    check("rd_req",  64'(obi_req),  64'd1);
    check("rd_addr", 64'(obi_addr), 64'h1000);
    check("rd_we",   64'(obi_we),   64'd0);
    check("rd_be",   64'(obi_be),   64'hF);
    check("rd_busy", 64'(busy),     64'd1);
    wait_rvalid(lat);
    check("rd_lat",   64'(lat),     64'd3);
    check("rd_rdata", 64'(s_rdata), 64'hDEADBEEF);
    check("rd_rresp", 64'(s_rresp), 64'd0);
    r_done();
    check("rd_rvalid_drop", 64'(s_rvalid), 64'd0);
    check("rd_idle", 64'(busy), 64'd0);

    // write with W two cycles ahead of AW
    x0 = n_xfer;
    aw_w(32'h0000_2004, 32'h12345678, 4'b0011, 2);
    wait_bvalid(lat);
    check("wr_bresp", 64'(s_bresp), 64'd0);
    b_done();
    check("wr_xfers", 64'(n_xfer - x0), 64'd1);
    check("wr_addr",  64'(snap_addr),  64'h2004);
    check("wr_we",    64'(snap_we),    64'd1);
    check("wr_be",    64'(snap_be),    64'h3);
    check("wr_wdata", 64'(snap_wdata), 64'h12345678);

    // grant withheld 5 cycles, another read pending meanwhile
    x0 = n_xfer; r0 = req_cycles; u0 = unstable; b0 = rdy_busy;
    gnt_delay = 5;
    slv_rdata = 32'h5555AAAA;
    ar_hs(32'h0000_0100);
    s_araddr  = 32'h0000_0200;
    s_arvalid = 1'b1;
    wait_rvalid(lat);
    check("slow_lat",      64'(lat),              64'd8);
    check("slow_req_cyc",  64'(req_cycles - r0),  64'd6);
    check("slow_unstable", 64'(unstable - u0),    64'd0);
    check("slow_xfers",    64'(n_xfer - x0),      64'd1);
    check("slow_ready",    64'(rdy_busy - b0),    64'd0);
    check("slow_addr",     64'(snap_addr),        64'h100);
    repeat (3) tick();
    check("slow_hold_rvalid", 64'(s_rvalid), 64'd1);
    check("slow_hold_rdata",  64'(s_rdata),  64'h5555AAAA);
    check("slow_arready",     64'(s_arready), 64'd0);
    r_done();
    gnt_delay = 0;
    slv_rdata = 32'h77778888;
    ar_hs(32'h0000_0200);
    wait_rvalid(lat);
    check("rd2_rdata", 64'(s_rdata), 64'h77778888);
    check("rd2_addr",  64'(snap_addr), 64'h200);
    r_done();

    // misaligned read: answered locally
    r0 = req_cycles;
    ar_hs(32'h0000_1002);
    wait_rvalid(lat);
    check("mis_rd_rresp", 64'(s_rresp), 64'd2);
    check("mis_rd_rdata", 64'(s_rdata), 64'd0);
    check("mis_rd_noreq", 64'(req_cycles - r0), 64'd0);
    r_done();

    // all channels pending: writes and reads alternate
    x0 = n_xfer;
    slv_rdata = 32'hCAFEF00D;
    s_awaddr  = 32'h0000_3000; s_awvalid = 1'b1;
    s_wdata   = 32'h11111111;  s_wstrb   = 4'hF; s_wvalid = 1'b1;
    s_araddr  = 32'h0000_3008; s_arvalid = 1'b1;
    s_bready  = 1'b1;
    s_rready  = 1'b1;
    nseen = 0;
    for (int i = 0; i < 200 && nseen < 4; i++) begin
      tick();
      if (s_bvalid) begin kinds[nseen] = 1'b1; nseen++; end
      else if (s_rvalid) begin kinds[nseen] = 1'b0; nseen++; end
    end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready  = 1'b0; s_rready = 1'b0;
    check("alt_count", 64'(nseen), 64'd4);
    for (int i = 0; i < 4; i++) begin
      exp_kind = (i % 2 == 0);
      check($sformatf("alt_order%0d", i), 64'(kinds[i]), 64'(exp_kind));
    end
    check("alt_xfers", 64'(n_xfer - x0), 64'd4);
    tick();
    check("alt_idle", 64'(busy), 64'd0);

    // misaligned write: answered locally
    x0 = n_xfer;
    aw_w(32'h0000_2006, 32'hA5A5A5A5, 4'hF, 0);
    wait_bvalid(lat);
    check("mis_wr_bresp", 64'(s_bresp), 64'd2);
    check("mis_wr_noxfer", 64'(n_xfer - x0), 64'd0);
    b_done();

    // zero strobe still issues with be=0
    x0 = n_xfer;
    aw_w(32'h0000_2008, 32'hFFFF0000, 4'h0, 0);
    wait_bvalid(lat);
    check("z_bresp", 64'(s_bresp), 64'd0);
    b_done();
    check("z_xfers", 64'(n_xfer - x0), 64'd1);
    check("z_be",    64'(snap_be),    64'd0);
    check("z_wdata", 64'(snap_wdata), 64'hFFFF0000);

    // reset during WAIT_R
    no_rsp = 1'b1;
    ar_hs(32'h0000_1000);
    tick();
    check("wr_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_obi_req", 64'(obi_req),  64'd0);
    check("rstw_bvalid",  64'(s_bvalid), 64'd0);
    check("rstw_rvalid",  64'(s_rvalid), 64'd0);
    check("rstw_busy",    64'(busy),     64'd0);
    tick(); tick();
    rst_n  = 1'b1;
    no_rsp = 1'b0;
    tick();

    // reset during REQ drops the request at once
    gnt_delay = 1000;
    ar_hs(32'h0000_1000);
    check("rq_req_pre", 64'(obi_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstq_obi_req", 64'(obi_req), 64'd0);
    check("rstq_busy",    64'(busy),    64'd0);
    tick(); tick();
    rst_n     = 1'b1;
    gnt_delay = 0;
    tick();

    // normal read after reset
    slv_rdata = 32'h0BADF00D;
    ar_hs(32'h0000_1000);
    wait_rvalid(lat);
    check("post_lat",   64'(lat),     64'd3);
    check("post_rdata", 64'(s_rdata), 64'h0BADF00D);
    check("post_rresp", 64'(s_rresp), 64'd0);
    r_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
